// File: rtl/mxu_out_fifo_axis.sv
// mxu_out_fifo_axis: buffers MXU result words and drains them over an
// AXI4-Stream master. Packets are closed by tlast on flush and, with
// MXU_OUTFIFO_PACKET_TLAST_EN defined, also every PACKET_LEN beats.
module mxu_out_fifo_axis #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int PACKET_LEN = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         outfifo_write,
  input  logic [DATA_WIDTH-1:0]        outfifo_din,
  output logic                         outfifo_is_full,
  output logic [$clog2(DEPTH+1)-1:0]   outfifo_count,
  input  logic                         flush,
  output logic                         flush_done,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         overflow_err,
  input  logic                         clear_err
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2} state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d, err_q, err_d;
  logic                  flush_pend_q, flush_pend_d, flush_done_q, flush_done_d;
  state_e                state_q, state_d;
  logic                  push, drop, pop, flush_act, force_last, pkt_last;

  assign push       = outfifo_write && (count_q < FULL_CNT);
  assign drop       = outfifo_write && (count_q == FULL_CNT);
  assign pop        = m_axis_tvalid && m_axis_tready;
  // A flush arriving on the final beat closes the packet on that same beat.
  assign flush_act  = flush_pend_q || flush;
  assign force_last = flush_act && (count_q == CW'(1)) && !push;

  assign m_axis_tvalid   = (count_q != '0);
  assign m_axis_tdata    = mem_q[rd_ptr_q];
  assign m_axis_tlast    = m_axis_tvalid && (force_last || pkt_last);
  assign outfifo_count   = count_q;
  assign outfifo_is_full = full_q;
  assign overflow_err    = err_q;
  assign flush_done      = flush_done_q;

`ifdef MXU_OUTFIFO_PACKET_TLAST_EN
  localparam int BW = $clog2(PACKET_LEN+1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(PACKET_LEN-1);
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  assign pkt_last = (beat_cnt_q == LAST_BEAT);

  // Beat position within the open packet; any tlast beat starts a new one.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop) beat_cnt_d = m_axis_tlast ? '0 : beat_cnt_q + BW'(1);
  end

  // Beat counter register.
  always_ff @(posedge clk) begin
    if (!reset) beat_cnt_q <= '0;
    else        beat_cnt_q <= beat_cnt_d;
  end
`else
  assign pkt_last = 1'b0;
`endif

  // Buffer write, pointer advance, occupancy and sticky overflow flag.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = outfifo_din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    full_d = (count_d == FULL_CNT);
    err_d  = drop || (err_q && !clear_err);
  end

  // Packet/flush state machine: next state, pending flag and done pulse.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    flush_done_d = 1'b0;
    if ((flush_act && count_q == '0) || (force_last && pop)) begin
      // Empty buffer cannot carry tlast, so an empty flush completes at once.
      flush_done_d = 1'b1;
      flush_pend_d = 1'b0;
      state_d      = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            flush_pend_d = 1'b1;
            state_d      = FLUSH;
          end else if (count_q != '0) begin
            state_d = STREAM;
          end
        end
        STREAM: begin
          if (flush) begin
            flush_pend_d = 1'b1;
            state_d      = FLUSH;
          end else if (count_d == '0) begin
            state_d = IDLE;
          end
        end
        FLUSH:   state_d = FLUSH;
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; reset also clears the array so tdata reads 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      state_q      <= IDLE;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      err_q        <= err_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
      state_q      <= state_d;
    end
  end
endmodule
